// File: rtl/ps2_key_ctrl_if.sv
// Bus between the ps2_keyboard receive FIFO, the key controller and the
// downstream display/LED logic. The controller drives the pop strobe and
// the decoded key state. The keyboard/environment side drives the FIFO head.
interface ps2_key_ctrl_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       kb_data;
  logic             kb_ready;
  logic             kb_overflow;
  logic             nextdata_n;
  logic             evt_valid;
  logic             evt_make;
  logic             evt_ext;
  logic [7:0]       evt_code;
  logic             key_down;
  logic [7:0]       held_code;
  logic             held_ext;
  logic [CNT_W-1:0] press_cnt;
  logic             ovf_err;

  modport master (
    input  kb_data, kb_ready, kb_overflow,
    output nextdata_n, evt_valid, evt_make, evt_ext, evt_code,
           key_down, held_code, held_ext, press_cnt, ovf_err
  );

  modport slave (
    output kb_data, kb_ready, kb_overflow,
    input  nextdata_n, evt_valid, evt_make, evt_ext, evt_code,
           key_down, held_code, held_ext, press_cnt, ovf_err
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: pops bytes from the ps2_keyboard FIFO one at a time and
// turns Set-2 scan codes (with E0 extended / F0 break prefixes) into clean
// make/break events, a held-key level and a press counter that ignores
// typematic repeats.
module ps2_key_ctrl #(
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  ps2_key_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, POP, GAP} pop_state_t;
  typedef enum logic [1:0] {P_NORM, P_E0, P_F0, P_E0F0} parse_state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  pop_state_t       pop_state;
  parse_state_t     parse_state;
  parse_state_t     parse_next;
  logic [7:0]       byte_r;
  logic             nextdata_n_r;
  logic             evt_valid_r;
  logic             evt_make_r;
  logic             evt_ext_r;
  logic [7:0]       evt_code_r;
  logic             key_down_r;
  logic [7:0]       held_code_r;
  logic             held_ext_r;
  logic [CNT_W-1:0] press_cnt_r;
  logic             ovf_err_r;
  logic             dec_evt;
  logic             dec_make;
  logic             dec_ext;
  logic             same_key;

  // Classify the latched byte against the current prefix context
  always_comb begin
    parse_next = parse_state;
    dec_evt    = 1'b0;
    dec_make   = 1'b0;
    dec_ext    = 1'b0;
    case (parse_state)
      P_NORM: begin
        if (byte_r == PFX_EXT) begin
          parse_next = P_E0;
        end else if (byte_r == PFX_BRK) begin
          parse_next = P_F0;
        end else begin
          dec_evt    = 1'b1;
          dec_make   = 1'b1;
          parse_next = P_NORM;
        end
      end
      P_E0: begin
        if (byte_r == PFX_BRK) begin
          parse_next = P_E0F0;
        end else if (byte_r == PFX_EXT) begin
          parse_next = P_E0;
        end else begin
          dec_evt    = 1'b1;
          dec_make   = 1'b1;
          dec_ext    = 1'b1;
          parse_next = P_NORM;
        end
      end
      P_F0: begin
        dec_evt    = 1'b1;
        parse_next = P_NORM;
      end
      P_E0F0: begin
        dec_evt    = 1'b1;
        dec_ext    = 1'b1;
        parse_next = P_NORM;
      end
      default: parse_next = P_NORM;
    endcase
    same_key = key_down_r && (byte_r == held_code_r) && (dec_ext == held_ext_r);
  end

  // Pop handshake (IDLE -> POP -> GAP), prefix parsing and held-key tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_state    <= IDLE;
      parse_state  <= P_NORM;
      byte_r       <= 8'h00;
      nextdata_n_r <= 1'b1;
      evt_valid_r  <= 1'b0;
      evt_make_r   <= 1'b0;
      evt_ext_r    <= 1'b0;
      evt_code_r   <= 8'h00;
      key_down_r   <= 1'b0;
      held_code_r  <= 8'h00;
      held_ext_r   <= 1'b0;
      press_cnt_r  <= '0;
      ovf_err_r    <= 1'b0;
    end else begin
      evt_valid_r <= 1'b0;
      if (bus.kb_overflow) begin
        ovf_err_r <= 1'b1;
      end
      case (pop_state)
        IDLE: begin
          if (bus.kb_ready) begin
            byte_r       <= bus.kb_data;
            nextdata_n_r <= 1'b0;
            pop_state    <= POP;
          end
        end
        POP: begin
          nextdata_n_r <= 1'b1;
          pop_state    <= GAP;
          parse_state  <= parse_next;
          if (dec_evt) begin
            if (dec_make) begin
              if (!same_key) begin
                evt_valid_r <= 1'b1;
                evt_make_r  <= 1'b1;
                evt_ext_r   <= dec_ext;
                evt_code_r  <= byte_r;
                press_cnt_r <= press_cnt_r + CNT_W'(1);
                key_down_r  <= 1'b1;
                held_code_r <= byte_r;
                held_ext_r  <= dec_ext;
              end
            end else begin
              evt_valid_r <= 1'b1;
              evt_make_r  <= 1'b0;
              evt_ext_r   <= dec_ext;
              evt_code_r  <= byte_r;
              if (same_key) begin
                key_down_r  <= 1'b0;
                held_code_r <= 8'h00;
                held_ext_r  <= 1'b0;
              end
            end
          end
        end
        GAP: begin
          pop_state <= IDLE;
        end
        default: pop_state <= IDLE;
      endcase
    end
  end

  assign bus.nextdata_n = nextdata_n_r;
  assign bus.evt_valid  = evt_valid_r;
  assign bus.evt_make   = evt_make_r;
  assign bus.evt_ext    = evt_ext_r;
  assign bus.evt_code   = evt_code_r;
  assign bus.key_down   = key_down_r;
  assign bus.held_code  = held_code_r;
  assign bus.held_ext   = held_ext_r;
  assign bus.press_cnt  = press_cnt_r;
  assign bus.ovf_err    = ovf_err_r;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Testbench for ps2_key_ctrl: a queue stands in for the ps2_keyboard FIFO,
// and a byte-level reference model tracks the expected key state.
module tb_ps2_key_ctrl;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int pops = 0;
  int evt_seen = 0;

  logic [7:0] fifo_q[$];
  logic [9:0] ev_log[$];

  bit         m_ext_pend;
  bit         m_brk_pend;
  bit         m_down;
  bit         m_held_ext;
  bit         m_valid;
  bit         m_make;
  bit         m_ext;
  logic [7:0] m_held_code;
  logic [7:0] m_code;
  int         m_cnt;

  ps2_key_ctrl_if #(.CNT_W(CNT_W)) bus ();

  ps2_key_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, 10 time units per cycle
  initial forever #5 clk = ~clk;

  // Hard stop in case a wait somewhere never resolves
  initial begin
    #600000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_ext_pend  = 0;
    m_brk_pend  = 0;
    m_down      = 0;
    m_held_ext  = 0;
    m_held_code = 8'h00;
    m_valid     = 0;
    m_make      = 0;
    m_ext       = 0;
    m_code      = 8'h00;
    m_cnt       = 0;
  endtask

  task automatic model_key(input bit make, input bit ext, input logic [7:0] code);
    bit same;
    same = m_down && (m_held_code == code) && (m_held_ext == ext);
    if (make) begin
      if (!same) begin
        m_valid     = 1;
        m_make      = 1;
        m_ext       = ext;
        m_code      = code;
        m_cnt       = (m_cnt + 1) % (1 << CNT_W);
        m_down      = 1;
        m_held_code = code;
        m_held_ext  = ext;
      end
    end else begin
      m_valid = 1;
      m_make  = 0;
      m_ext   = ext;
      m_code  = code;
      if (same) begin
        m_down      = 0;
        m_held_code = 8'h00;
        m_held_ext  = 0;
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_brk_pend) begin
      model_key(0, m_ext_pend, b);
      m_brk_pend = 0;
      m_ext_pend = 0;
    end else if (b == 8'hE0) begin
      m_ext_pend = 1;
    end else if (b == 8'hF0) begin
      m_brk_pend = 1;
    end else begin
      model_key(1, m_ext_pend, b);
      m_ext_pend = 0;
    end
  endtask

  // FIFO stand-in plus per-cycle comparison of the DUT against the model
  initial begin
    bit do_pop;
    bit rst_s;
    bit prev_low;
    prev_low = 0;
    bus.kb_ready = 1'b0;
    bus.kb_data  = 8'h00;
    model_reset();
    forever begin
      @(negedge clk);
      check_output("cyc_evt_valid", bus.evt_valid, m_valid);
      check_output("cyc_evt_make", bus.evt_make, m_make);
      check_output("cyc_evt_ext", bus.evt_ext, m_ext);
      check_output("cyc_evt_code", bus.evt_code, m_code);
      check_output("cyc_key_down", bus.key_down, m_down);
      check_output("cyc_held_code", bus.held_code, m_held_code);
      check_output("cyc_held_ext", bus.held_ext, m_held_ext);
      check_output("cyc_press_cnt", bus.press_cnt, m_cnt);
      if (prev_low) check_output("pop_one_cycle", bus.nextdata_n, 1);
      prev_low = (bus.nextdata_n === 1'b0);
      if (bus.evt_valid === 1'b1) begin
        evt_seen++;
        ev_log.push_back({bus.evt_make, bus.evt_ext, bus.evt_code});
      end
      #1;
      do_pop = (bus.nextdata_n === 1'b0) && !rst;
      rst_s  = rst;
      @(posedge clk);
      #1;
      m_valid = 0;
      if (rst_s) begin
        model_reset();
      end else if (do_pop) begin
        check_output("pop_nonempty", fifo_q.size() != 0, 1);
        if (fifo_q.size() != 0) begin
          pops++;
          model_byte(fifo_q.pop_front());
        end
      end
      bus.kb_ready = (fifo_q.size() != 0);
      bus.kb_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (fifo_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, fifo_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // Directed sequences from the test plan, then a randomized byte stream
  initial begin
    int p0;
    int e0;
    int l0;
    int n;
    int lows;
    logic [7:0] pool[5];
    logic [7:0] c;
    pool[0] = 8'h1C; pool[1] = 8'h23; pool[2] = 8'h15; pool[3] = 8'h75; pool[4] = 8'h6B;
    bus.kb_overflow = 1'b0;

    do_reset();
    check_output("rst_nextdata_n", bus.nextdata_n, 1);
    check_output("rst_evt_valid", bus.evt_valid, 0);
    check_output("rst_evt_make", bus.evt_make, 0);
    check_output("rst_evt_ext", bus.evt_ext, 0);
    check_output("rst_evt_code", bus.evt_code, 0);
    check_output("rst_key_down", bus.key_down, 0);
    check_output("rst_held_code", bus.held_code, 0);
    check_output("rst_held_ext", bus.held_ext, 0);
    check_output("rst_press_cnt", bus.press_cnt, 0);
    check_output("rst_ovf_err", bus.ovf_err, 0);

    // Single make of 15
    p0 = pops; e0 = evt_seen;
    apply_stimulus(8'h15);
    wait_drain("drain_single", 50);
    check_output("single_events", evt_seen - e0, 1);
    check_output("single_pops", pops - p0, 1);
    check_output("single_make", bus.evt_make, 1);
    check_output("single_code", bus.evt_code, 8'h15);
    check_output("single_ext", bus.evt_ext, 0);
    check_output("single_key_down", bus.key_down, 1);
    check_output("single_held_code", bus.held_code, 8'h15);
    check_output("single_press_cnt", bus.press_cnt, 1);

    // Typematic repeat then break
    do_reset();
    p0 = pops; e0 = evt_seen;
    apply_stimulus(8'h15); apply_stimulus(8'h15); apply_stimulus(8'h15);
    apply_stimulus(8'hF0); apply_stimulus(8'h15);
    wait_drain("drain_repeat", 100);
    check_output("repeat_events", evt_seen - e0, 2);
    check_output("repeat_pops", pops - p0, 5);
    check_output("repeat_press_cnt", bus.press_cnt, 1);
    check_output("repeat_make", bus.evt_make, 0);
    check_output("repeat_code", bus.evt_code, 8'h15);
    check_output("repeat_key_down", bus.key_down, 0);
    check_output("repeat_held_code", bus.held_code, 0);

    // Extended make and break
    do_reset();
    e0 = evt_seen;
    apply_stimulus(8'hE0); apply_stimulus(8'h75); apply_stimulus(8'hE0);
    apply_stimulus(8'hF0); apply_stimulus(8'h75);
    wait_drain("drain_ext", 100);
    check_output("ext_events", evt_seen - e0, 2);
    check_output("ext_make", bus.evt_make, 0);
    check_output("ext_ext", bus.evt_ext, 1);
    check_output("ext_code", bus.evt_code, 8'h75);
    check_output("ext_press_cnt", bus.press_cnt, 1);
    check_output("ext_key_down", bus.key_down, 0);

    // Last press wins, break of an older key leaves the held key alone
    do_reset();
    e0 = evt_seen;
    apply_stimulus(8'h1C); apply_stimulus(8'h23); apply_stimulus(8'hF0); apply_stimulus(8'h1C);
    wait_drain("drain_two", 100);
    check_output("two_events", evt_seen - e0, 3);
    check_output("two_press_cnt", bus.press_cnt, 2);
    check_output("two_key_down", bus.key_down, 1);
    check_output("two_held_code", bus.held_code, 8'h23);
    check_output("two_code", bus.evt_code, 8'h1C);

    // Reset during the pop of the second queued byte
    do_reset();
    apply_stimulus(8'hE0); apply_stimulus(8'h75); apply_stimulus(8'h6B); apply_stimulus(8'h74);
    lows = 0; n = 0;
    while (lows < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.nextdata_n === 1'b0) lows++;
    end
    check_output("midrst_found_pop", lows, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("midrst_nextdata_n", bus.nextdata_n, 1);
    check_output("midrst_evt_valid", bus.evt_valid, 0);
    check_output("midrst_key_down", bus.key_down, 0);
    check_output("midrst_press_cnt", bus.press_cnt, 0);
    check_output("midrst_fifo_left", fifo_q.size(), 3);
    p0 = pops; l0 = ev_log.size();
    rst = 1'b0;
    wait_drain("drain_midrst", 100);
    check_output("midrst_pops", pops - p0, 3);
    check_output("midrst_events", ev_log.size() - l0, 3);
    if (ev_log.size() > l0) check_output("midrst_first_evt", ev_log[l0], {1'b1, 1'b0, 8'h75});
    check_output("midrst_press_cnt_after", bus.press_cnt, 3);
    check_output("midrst_held_code", bus.held_code, 8'h74);

    // 256 make/break pairs wrap the press counter
    do_reset();
    e0 = evt_seen;
    for (int i = 0; i < 256; i++) begin
      c = 8'(1 + (i % 128));
      if (i >= 128) apply_stimulus(8'hE0);
      apply_stimulus(c);
      if (i >= 128) apply_stimulus(8'hE0);
      apply_stimulus(8'hF0);
      apply_stimulus(c);
    end
    wait_drain("drain_wrap", 6000);
    check_output("wrap_events", evt_seen - e0, 512);
    check_output("wrap_press_cnt", bus.press_cnt, 0);
    check_output("wrap_key_down", bus.key_down, 0);

    // Overflow flag is sticky until reset
    @(negedge clk);
    bus.kb_overflow = 1'b1;
    @(negedge clk);
    bus.kb_overflow = 1'b0;
    check_output("ovf_set", bus.ovf_err, 1);
    repeat (5) @(negedge clk);
    check_output("ovf_sticky", bus.ovf_err, 1);
    do_reset();
    check_output("ovf_cleared", bus.ovf_err, 0);

    // Randomized byte stream with irregular arrival gaps
    p0 = pops;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 99);
      if (n < 10) c = 8'hE0;
      else if (n < 25) c = 8'hF0;
      else if (n < 90) c = pool[$urandom_range(0, 4)];
      else c = 8'($urandom_range(1, 8'hDF));
      apply_stimulus(c);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain("drain_random", 2000);
    check_output("random_pops", pops - p0, 300);
    check_output("random_press_cnt", bus.press_cnt, m_cnt);
    check_output("random_key_down", bus.key_down, m_down);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
